// File: rtl/uart_fifo_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_tx
// Brief    : UART transmitter draining a FIFO read port, 8N1/8E1/8O1, 1-2 stop.
// Revision : 1.0
// ============================================================================
module uart_fifo_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_rd_empty,
    output logic       fifo_rd_en,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
    localparam int c_cnt_w        = $clog2(c_clks_per_bit);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic               c_stop_last = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_data   = 3'd4;
    localparam logic [2:0] c_st_parity = 3'd5;
    localparam logic [2:0] c_st_stop   = 3'd6;

    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_txd;
    logic               r_done;

    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] w_baud_next;
    logic [2:0]         w_bit_next;
    logic               w_stop_next;
    logic               w_rd_en;
    logic               w_done_next;
    logic               w_txd_next;
    logic               w_tick;

    assign w_tick = (r_baud_cnt == c_cnt_last);

    // Counter defaults to 0 so every state entry (always on a tick) starts a fresh bit time.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = '0;
        w_bit_next   = 3'd0;
        w_stop_next  = 1'b0;
        w_rd_en      = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (tx_en && !fifo_rd_empty) begin
                    w_state_next = c_st_fetch;
                end
            end
            c_st_fetch: begin
                w_rd_en      = 1'b1;
                w_state_next = c_st_load;
            end
            c_st_load: begin
                w_state_next = c_st_start;
            end
            c_st_start: begin
                if (w_tick) begin
                    w_state_next = c_st_data;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            c_st_data: begin
                w_bit_next = r_bit_idx;
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = PARITY_EN ? c_st_parity : c_st_stop;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            c_st_parity: begin
                if (w_tick) begin
                    w_state_next = c_st_stop;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            c_st_stop: begin
                w_stop_next = r_stop_idx;
                if (w_tick) begin
                    if (r_stop_idx == c_stop_last) begin
                        w_state_next = c_st_idle;
                        w_done_next  = 1'b1;
                    end else begin
                        w_stop_next = 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // The line level is decoded from the next state so uart_txd can be a flop.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            c_st_start:  w_txd_next = 1'b0;
            c_st_data:   w_txd_next = r_shift[w_bit_next];
            c_st_parity: w_txd_next = r_parity;
            default:     w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_txd      <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_stop_idx <= w_stop_next;
            if (r_state == c_st_load) begin
                r_shift  <= fifo_rd_data;
                r_parity <= (^fifo_rd_data) ^ PARITY_ODD;
            end
            r_txd      <= w_txd_next;
            r_done     <= w_done_next;
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign uart_txd   = r_txd;
    assign tx_busy    = (r_state != c_st_idle);
    assign tx_done    = r_done;

endmodule
`default_nettype wire
